piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//  Parallel-in/serial-out transmitter: the sending end of the team's serial shift-register link.
//  Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out one bit per shift_en strike.
//  Frames each word with ser_frame and pulses done after the last bit.
//  Back-to-back words stream with no gap bit.
//  Sits between a parallel producer (FSM/FIFO) and the serial line feeding the SIPO receiver.
// PARAMETERS
//  WIDTH      8  bits per word; legal range >= 2
//  LSB_FIRST  0  0: bit WIDTH-1 is sent first; 1: bit 0 is sent first
// PORTS
//  clk         in   1      system clock; all state changes on the rising edge
//  reset       in   1      asynchronous, active-high reset
//  load_valid  in   1      producer has a word on load_data
//  load_ready  out  1      block accepts the word this cycle
//  load_data   in   WIDTH  word to serialize; sampled only on handshake
//  shift_en    in   1      bit-rate strobe; one bit is advanced per cycle with shift_en=1
//  ser_out     out  1      serial data; driven from a register, never combinational from inputs
//  ser_frame   out  1      high while ser_out carries a valid word bit
//  done        out  1      one-cycle pulse: the final bit of a word has been consumed
// BEHAVIOUR
//  Reset (async, any time, including mid-frame):
//   - state=IDLE, shreg=0, bit count=0
//   - ser_out=0, ser_frame=0, done=0
//   - load_ready=1 once reset deasserts
//   - A partially sent word is dropped; no done pulse for it.
//  States:
//   - IDLE:  load_ready=1; shift_en is ignored.
//   - SHIFT: load_ready=0, except on the last-bit cycle (below).
//  Handshake:
//   - Transfer occurs on the edge where load_valid & load_ready = 1.
//   - load_valid with load_ready=0 has no effect; load_data is don't-care.
//  IDLE -> SHIFT on transfer:
//   - shreg <= load_data, count <= 0.
//   - Next cycle: ser_frame=1 and ser_out = first bit.
//   - Latency from handshake edge to first bit visible: 1 cycle.
//  SHIFT, shift_en=1, count < WIDTH-1:
//   - shreg shifts toward the output end, count++.
//  SHIFT, shift_en=0:
//   - Hold; ser_out/ser_frame/count are unchanged (stall of any length).
//  Last bit (SHIFT & count==WIDTH-1 & shift_en=1):
//   - load_ready=1 combinationally; this is the only comb path (shift_en -> load_ready).
//   - done<=1 on the same edge; done is a one-cycle pulse.
//   - Transfer on this edge: reload shreg, count<=0, stay in SHIFT; new word's first bit
//     follows the old last bit with no gap, and ser_frame stays 1.
//   - No transfer: go to IDLE; next cycle ser_frame=0, ser_out=0.
//  Every word holds ser_frame high for exactly WIDTH shift_en strikes.
//  Count register width: $clog2(WIDTH); it never exceeds WIDTH-1.
//  Counter wrap: WIDTH-1 -> 0 occurs only via reload or exit to IDLE.
//  Output bit:
//   - ser_out = shreg[WIDTH-1] when LSB_FIRST=0, shreg[0] when LSB_FIRST=1.
//   - Vacated bits are zero-filled.
// STRUCTURE
//  Shared package piso_pkg:
//   - state encoding localparams ST_IDLE=1'b0, ST_SHIFT=1'b1
//   - function clog2 for the count width
//  One sub-module: piso_shift_core (WIDTH, LSB_FIRST; load, shift, din -> sout), register only.
//  Top holds the FSM, the bit counter, the handshake and done.
// TESTING (WIDTH=8 unless noted)
//  1 Load 8'hA5, LSB_FIRST=0, shift_en=1 constant
//     -> ser_out 1,0,1,0,0,1,0,1 on cycles 1..8 after handshake; ser_frame=1 for those 8 cycles;
//        done=1 on the edge of the 8th bit only; then IDLE with ser_out=0.
//  2 LSB_FIRST=1, load 8'h01
//     -> ser_out 1,0,0,0,0,0,0,0.
//  3 shift_en toggling 1,0,1,0
//     -> each bit is held 2 cycles; ser_frame lasts 16 cycles; exactly one done pulse.
//  4 load_valid held high with words 8'hF0 then 8'h0F
//     -> 16 contiguous frame bits 11110000 00001111; load_ready high only on the bit-8 cycle;
//        two done pulses, 8 strikes apart.
//  5 Assert reset after 3 bits of 8'hFF
//     -> same cycle: ser_out=0, ser_frame=0; no done; load_ready=1 after release;
//        next word sent intact.
//  6 load_valid=1 while in SHIFT before the last bit
//     -> ignored; the word in flight is unchanged; the new word is taken only at the
//        last-bit edge.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer: FSM state encoding and a
// constant ceil-log2 helper used to size the bit counter.
package piso_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/piso_shift_core.sv
// Load/shift register for the serializer; zero-fills vacated bits and
// presents the output-end bit as sout.
module piso_shift_core #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    logic [WIDTH-1:0] shreg_d;
    logic [WIDTH-1:0] shreg_q;

    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = din;
        end else if (shift) begin
            if (LSB_FIRST) begin
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end else begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign sout = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: valid/ready word intake, one bit per
// shift_en strike, ser_frame while bits are on the line, done after the last bit.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_frame,
    output logic             done
);

    localparam int unsigned          CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0]     LAST  = CNT_W'(WIDTH - 1);

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              done_q;
    logic              done_d;
    logic              last_bit;
    logic              xfer;
    logic              core_load;
    logic              core_shift;

    always_comb begin
        last_bit   = (state_q == ST_SHIFT) && shift_en && (count_q == LAST);
        load_ready = (state_q == ST_IDLE) || last_bit;
        xfer       = load_valid && load_ready;

        state_d    = state_q;
        count_d    = count_q;
        done_d     = 1'b0;
        core_load  = xfer;
        core_shift = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    state_d = ST_SHIFT;
                    count_d = '0;
                end
            end
            ST_SHIFT: begin
                if (shift_en) begin
                    if (last_bit) begin
                        done_d  = 1'b1;
                        count_d = '0;
                        // Exiting shifts out the last bit so ser_out idles at zero.
                        if (!xfer) begin
                            state_d    = ST_IDLE;
                            core_shift = 1'b1;
                        end
                    end else begin
                        count_d    = count_q + CNT_W'(1);
                        core_shift = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    piso_shift_core #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .load  (core_load),
        .shift (core_shift),
        .din   (load_data),
        .sout  (ser_out)
    );

    assign ser_frame = (state_q == ST_SHIFT);
    assign done      = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus;
// expected serial bits are queued at handshake time and consumed per strike.
module tb_piso_serializer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_valid;
    logic         shift_en;
    logic [W-1:0] load_data;
    logic         load_ready0, ser_out0, ser_frame0, done0;
    logic         load_ready1, ser_out1, ser_frame1, done1;

    int errors = 0;
    int checks = 0;
    logic q0[$];
    logic q1[$];

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready0),
        .load_data  (load_data),
        .shift_en   (shift_en),
        .ser_out    (ser_out0),
        .ser_frame  (ser_frame0),
        .done       (done0)
    );

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready1),
        .load_data  (load_data),
        .shift_en   (shift_en),
        .ser_out    (ser_out1),
        .ser_frame  (ser_frame1),
        .done       (done1)
    );

    task automatic push_word(input logic [W-1:0] d);
        for (int unsigned i = 0; i < W; i++) begin
            q0.push_back(d[W-1-i]);
            q1.push_back(d[i]);
        end
    endtask

    function automatic logic head0();
        return (q0.size() > 0) ? q0[0] : 1'bx;
    endfunction

    function automatic logic head1();
        return (q1.size() > 0) ? q1[0] : 1'bx;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({ser_out0, ser_out1, ser_frame0, ser_frame1, done0, done1} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=000000",
                     {ser_out0, ser_out1, ser_frame0, ser_frame1, done0, done1});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({load_ready0, load_ready1} !== 2'b11) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=11", {load_ready0, load_ready1});
        end
        checks++;
        if ({ser_out0, ser_out1, ser_frame0, ser_frame1, done0, done1} !== 6'b0) begin
            errors++;
            $display("FAIL reset_release_outputs got=%b exp=000000",
                     {ser_out0, ser_out1, ser_frame0, ser_frame1, done0, done1});
        end
        @(negedge clk);
    endtask

    task automatic test_single(input logic [W-1:0] data);
        logic e0, e1, ef, ed, er;
        load_valid = 1'b1;
        load_data  = data;
        shift_en   = 1'b1;
        #1;
        checks++;
        if ({load_ready0, load_ready1} !== 2'b11) begin
            errors++;
            $display("FAIL single_accept data=%h got=%b exp=11", data, {load_ready0, load_ready1});
        end
        push_word(data);
        @(negedge clk);
        load_valid = 1'b0;
        load_data  = '0;
        for (int c = 0; c < 10; c++) begin
            #1;
            ef = (c < 8);
            ed = (c == 8);
            er = (c >= 7);
            e0 = ef ? head0() : 1'b0;
            e1 = ef ? head1() : 1'b0;
            checks++;
            if ({ser_frame0, ser_frame1} !== {ef, ef}) begin
                errors++;
                $display("FAIL single_frame data=%h c=%0d got=%b exp=%b", data, c, {ser_frame0, ser_frame1}, {ef, ef});
            end
            checks++;
            if ({ser_out0, ser_out1} !== {e0, e1}) begin
                errors++;
                $display("FAIL single_bit data=%h c=%0d got=%b exp=%b", data, c, {ser_out0, ser_out1}, {e0, e1});
            end
            checks++;
            if ({done0, done1} !== {ed, ed}) begin
                errors++;
                $display("FAIL single_done data=%h c=%0d got=%b exp=%b", data, c, {done0, done1}, {ed, ed});
            end
            checks++;
            if ({load_ready0, load_ready1} !== {er, er}) begin
                errors++;
                $display("FAIL single_ready data=%h c=%0d got=%b exp=%b", data, c, {load_ready0, load_ready1}, {er, er});
            end
            if (ef && shift_en) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall(input logic [W-1:0] data);
        logic e0, e1, ef, ed, er;
        int   dones;
        dones      = 0;
        load_valid = 1'b1;
        load_data  = data;
        shift_en   = 1'b0;
        push_word(data);
        @(negedge clk);
        load_valid = 1'b0;
        for (int c = 0; c < 18; c++) begin
            shift_en = (c % 2 == 1);
            #1;
            ef = (c < 16);
            ed = (c == 16);
            er = (c == 15) || (c >= 16);
            e0 = ef ? head0() : 1'b0;
            e1 = ef ? head1() : 1'b0;
            if (done0) dones++;
            checks++;
            if ({ser_frame0, ser_frame1} !== {ef, ef}) begin
                errors++;
                $display("FAIL stall_frame c=%0d got=%b exp=%b", c, {ser_frame0, ser_frame1}, {ef, ef});
            end
            checks++;
            if ({ser_out0, ser_out1} !== {e0, e1}) begin
                errors++;
                $display("FAIL stall_bit c=%0d got=%b exp=%b", c, {ser_out0, ser_out1}, {e0, e1});
            end
            checks++;
            if ({done0, done1} !== {ed, ed}) begin
                errors++;
                $display("FAIL stall_done c=%0d got=%b exp=%b", c, {done0, done1}, {ed, ed});
            end
            checks++;
            if ({load_ready0, load_ready1} !== {er, er}) begin
                errors++;
                $display("FAIL stall_ready c=%0d got=%b exp=%b", c, {load_ready0, load_ready1}, {er, er});
            end
            if (ef && shift_en) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
            @(negedge clk);
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL stall_done_count got=%0d exp=1", dones);
        end
    endtask

    task automatic test_back_to_back();
        logic e0, e1, ef, ed, er;
        load_valid = 1'b1;
        load_data  = 8'hF0;
        shift_en   = 1'b1;
        push_word(8'hF0);
        @(negedge clk);
        load_data = 8'h0F;
        for (int c = 0; c < 18; c++) begin
            if (c == 15) load_valid = 1'b0;
            #1;
            ef = (c < 16);
            ed = (c == 8) || (c == 16);
            er = (c == 7) || (c == 15) || (c >= 16);
            e0 = ef ? head0() : 1'b0;
            e1 = ef ? head1() : 1'b0;
            checks++;
            if ({ser_frame0, ser_frame1} !== {ef, ef}) begin
                errors++;
                $display("FAIL b2b_frame c=%0d got=%b exp=%b", c, {ser_frame0, ser_frame1}, {ef, ef});
            end
            checks++;
            if ({ser_out0, ser_out1} !== {e0, e1}) begin
                errors++;
                $display("FAIL b2b_bit c=%0d got=%b exp=%b", c, {ser_out0, ser_out1}, {e0, e1});
            end
            checks++;
            if ({done0, done1} !== {ed, ed}) begin
                errors++;
                $display("FAIL b2b_done c=%0d got=%b exp=%b", c, {done0, done1}, {ed, ed});
            end
            checks++;
            if ({load_ready0, load_ready1} !== {er, er}) begin
                errors++;
                $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, {load_ready0, load_ready1}, {er, er});
            end
            if (ef && shift_en) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
            if (c == 7) push_word(8'h0F);
            @(negedge clk);
        end
    endtask

    task automatic test_ignore();
        logic e0, e1, ef, ed, er;
        load_valid = 1'b1;
        load_data  = 8'h96;
        shift_en   = 1'b1;
        push_word(8'h96);
        @(negedge clk);
        for (int c = 0; c < 18; c++) begin
            load_valid = (c >= 2) && (c <= 7);
            load_data  = (c == 7) ? 8'h5A : 8'hFF;
            #1;
            ef = (c < 16);
            ed = (c == 8) || (c == 16);
            er = (c == 7) || (c == 15) || (c >= 16);
            e0 = ef ? head0() : 1'b0;
            e1 = ef ? head1() : 1'b0;
            checks++;
            if ({ser_frame0, ser_frame1} !== {ef, ef}) begin
                errors++;
                $display("FAIL ignore_frame c=%0d got=%b exp=%b", c, {ser_frame0, ser_frame1}, {ef, ef});
            end
            checks++;
            if ({ser_out0, ser_out1} !== {e0, e1}) begin
                errors++;
                $display("FAIL ignore_bit c=%0d got=%b exp=%b", c, {ser_out0, ser_out1}, {e0, e1});
            end
            checks++;
            if ({done0, done1} !== {ed, ed}) begin
                errors++;
                $display("FAIL ignore_done c=%0d got=%b exp=%b", c, {done0, done1}, {ed, ed});
            end
            checks++;
            if ({load_ready0, load_ready1} !== {er, er}) begin
                errors++;
                $display("FAIL ignore_ready c=%0d got=%b exp=%b", c, {load_ready0, load_ready1}, {er, er});
            end
            if (ef && shift_en) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
            if (c == 7) push_word(8'h5A);
            @(negedge clk);
        end
        load_valid = 1'b0;
        load_data  = '0;
    endtask

    task automatic test_reset_midframe();
        logic e0, e1;
        load_valid = 1'b1;
        load_data  = 8'hFF;
        shift_en   = 1'b1;
        push_word(8'hFF);
        @(negedge clk);
        load_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            e0 = head0();
            e1 = head1();
            checks++;
            if ({ser_frame0, ser_frame1, ser_out0, ser_out1} !== {2'b11, e0, e1}) begin
                errors++;
                $display("FAIL midreset_pre c=%0d got=%b exp=%b", c,
                         {ser_frame0, ser_frame1, ser_out0, ser_out1}, {2'b11, e0, e1});
            end
            void'(q0.pop_front());
            void'(q1.pop_front());
            @(negedge clk);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({ser_out0, ser_out1, ser_frame0, ser_frame1, done0, done1} !== 6'b0) begin
            errors++;
            $display("FAIL midreset_async got=%b exp=000000",
                     {ser_out0, ser_out1, ser_frame0, ser_frame1, done0, done1});
        end
        q0.delete();
        q1.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({load_ready0, load_ready1, ser_frame0, ser_frame1, done0, done1} !== 6'b110000) begin
                errors++;
                $display("FAIL midreset_after c=%0d got=%b exp=110000", c,
                         {load_ready0, load_ready1, ser_frame0, ser_frame1, done0, done1});
            end
            @(negedge clk);
        end
        test_single(8'hC3);
    endtask

    initial begin
        reset      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        shift_en   = 1'b0;
        test_reset();
        test_single(8'hA5);
        test_single(8'h01);
        test_stall(8'hC6);
        test_back_to_back();
        test_reset_midframe();
        test_ignore();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
